mode_counter: RTL

Parametrised up/down counter with programmable modulo limit, load, clock-enable prescaler and three terminal-count modes (wrap, saturate, one-shot). It is the general-purpose event/interval counter for timers, packet-length tracking and rate dividers. It replaces free-running fixed-width counters wherever a design needs a limit, a direction or a terminal-count indication.

---
 rtl/mode_counter.sv | 101 ++++++++++
 1 files changed

// File: rtl/mode_counter.sv
// Up/down counter with modulo limit, load, enable prescaler and
// wrap / saturate / one-shot terminal-count behaviour.
//
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   en             : count enable (prescaler and counter hold when low)
//   up_dn          : 1 = up, 0 = down
//   load, load_val : synchronous load, value clamped to limit
//   limit          : count range is 0..limit
//   mode           : 00 wrap, 01 saturate, 10 one-shot, 11 wrap
//   cnt_o          : registered count
//   flag           : combinational terminal decode for current direction
//   tc_o           : registered one-cycle terminal-event pulse
//   done_o         : sticky one-shot completion
module mode_counter #(
  parameter int WIDTH     = 8,
  parameter int PRESCALE  = 1,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] cnt_o,
  output logic             flag,
  output logic             tc_o,
  output logic             done_o
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(RESET_VAL);

  typedef enum logic {
    S_RUN  = 1'b0,
    S_DONE = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             tc_q, tc_d;
  logic             tick;

  // A count above a lowered limit is terminal when counting up,
  // so the >= compare (not ==) is deliberate.
  assign flag = up_dn ? (cnt_q >= limit) : (cnt_q == '0);
  assign tick = en && (pre_q == PRE_MAX);

  always_comb begin
    cnt_d   = cnt_q;
    pre_d   = pre_q;
    state_d = state_q;
    tc_d    = 1'b0;
    if (load) begin
      cnt_d   = (load_val > limit) ? limit : load_val;
      pre_d   = '0;
      state_d = S_RUN;
    end else if (en) begin
      pre_d = tick ? '0 : pre_q + 1'b1;
      // Once the one-shot has fired, ticks are swallowed until
      // load or reset.
      if (tick && state_q == S_RUN) begin
        if (!flag) begin
          cnt_d = up_dn ? cnt_q + 1'b1 : cnt_q - 1'b1;
        end else begin
          tc_d = 1'b1;
          unique case (mode)
            2'b01: begin
            end
            2'b10: state_d = S_DONE;
            default: cnt_d = up_dn ? '0 : limit;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= RST_CNT;
      pre_q   <= '0;
      tc_q    <= 1'b0;
      state_q <= S_RUN;
    end else begin
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      tc_q    <= tc_d;
      state_q <= state_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign tc_o   = tc_q;
  assign done_o = (state_q == S_DONE);

endmodule
